dds_phase_accumulator: RTL and testbench

- Numerically controlled phase generator; sits directly upstream of the sine ROM and drives its phase address input.
- Accumulates a frequency tuning word (FTW) each enabled cycle and adds a phase offset.
- Truncates the result to `ROM_PHASE_BIT bits and flags every accumulator wrap.
- FTW changes are either immediate or deferred to the next wrap, giving phase-continuous frequency changes.

---
 rtl/dds_phase_accumulator.sv | 124 ++++++++++++
 tb/tb_dds_phase_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: FTW accumulation, phase offset, truncation to `ROM_PHASE_BIT and wrap flag.
// Optional truncation dither via LFSR when PHASE_DITHER_EN is defined.
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif

module dds_phase_accumulator #(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [ACC_WIDTH-1:0]      ftw_in,
    input  logic                      ftw_load,
    input  logic                      ftw_sync_mode,
    input  logic [ACC_WIDTH-1:0]      poff_in,
    input  logic                      phase_clr,
    output logic [`ROM_PHASE_BIT-1:0] phase,
    output logic                      phase_valid,
    output logic                      wrap,
    output logic                      ftw_pending,
    output logic [ACC_WIDTH-1:0]      ftw_active
);

    localparam int unsigned PW = `ROM_PHASE_BIT;

    typedef enum logic {
        IDLE,
        PENDING
    } ftw_state_t;

    ftw_state_t           state, state_n;
    logic [ACC_WIDTH-1:0] acc, acc_n;
    logic [ACC_WIDTH-1:0] ftw_shadow, shadow_n, active_n;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 carry;
    logic                 commit;
    logic [ACC_WIDTH-1:0] dither_term;
    logic [ACC_WIDTH-1:0] phase_sum;
    logic [PW-1:0]        phase_n;

    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, ftw_active};
        carry   = acc_sum[ACC_WIDTH];
        acc_n   = acc;
        if (phase_clr)
            acc_n = '0;
        else if (en)
            acc_n = acc_sum[ACC_WIDTH-1:0];
    end

`ifdef PHASE_DITHER_EN
    localparam int unsigned DISC  = ACC_WIDTH - PW;
    localparam int unsigned DBITS = (DISC < 16) ? DISC : 16;
    localparam logic [ACC_WIDTH-1:0] DMASK = (ACC_WIDTH'(1) << DBITS) - ACC_WIDTH'(1);

    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= 16'hACE1;
        else if (en)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign dither_term = ACC_WIDTH'(lfsr) & DMASK;
`else
    assign dither_term = '0;
`endif

    // Phase is built from the post-update accumulator so it lines up with wrap.
    assign phase_sum = acc_n + poff_in + dither_term;
    assign phase_n   = PW'(phase_sum >> (ACC_WIDTH - PW));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            acc         <= acc_n;
            if (en || phase_clr)
                phase <= phase_n;
            phase_valid <= en;
            wrap        <= en & carry & ~phase_clr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ftw_active <= '0;
            ftw_shadow <= '0;
        end else begin
            state      <= state_n;
            ftw_active <= active_n;
            ftw_shadow <= shadow_n;
        end
    end

    // A deferred load arriving with a commit refills the shadow after the old value commits.
    always_comb begin
        state_n  = state;
        active_n = ftw_active;
        shadow_n = ftw_shadow;
        commit   = (state == PENDING) && en && carry && !phase_clr;
        if (commit) begin
            active_n = ftw_shadow;
            state_n  = IDLE;
        end
        if (ftw_load && !ftw_sync_mode) begin
            active_n = ftw_in;
            state_n  = IDLE;
        end else if (ftw_load && ftw_sync_mode) begin
            shadow_n = ftw_in;
            state_n  = PENDING;
        end
    end

    assign ftw_pending = (state == PENDING);

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed testbench for dds_phase_accumulator (ACC_WIDTH=32, ROM_PHASE_BIT=10, no dither).
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif

module tb_dds_phase_accumulator;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] ftw_in;
    logic        ftw_load;
    logic        ftw_sync_mode;
    logic [31:0] poff_in;
    logic        phase_clr;
    logic [`ROM_PHASE_BIT-1:0] phase;
    logic        phase_valid;
    logic        wrap;
    logic        ftw_pending;
    logic [31:0] ftw_active;

    int n_cmp = 0;
    int n_err = 0;
    int wraps;

    dds_phase_accumulator #(.ACC_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .ftw_in        (ftw_in),
        .ftw_load      (ftw_load),
        .ftw_sync_mode (ftw_sync_mode),
        .poff_in       (poff_in),
        .phase_clr     (phase_clr),
        .phase         (phase),
        .phase_valid   (phase_valid),
        .wrap          (wrap),
        .ftw_pending   (ftw_pending),
        .ftw_active    (ftw_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ph, input logic vld, input logic wr);
        chk({tag, ".phase"}, 32'(phase), ph);
        chk({tag, ".valid"}, 32'(phase_valid), 32'(vld));
        chk({tag, ".wrap"}, 32'(wrap), 32'(wr));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ftw_in = '0; ftw_load = 1'b0;
        ftw_sync_mode = 1'b0; poff_in = '0; phase_clr = 1'b0;

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); ftw_in = $urandom; ftw_load = 1'($urandom);
            ftw_sync_mode = 1'($urandom); poff_in = $urandom; phase_clr = 1'($urandom);
            step();
            chk_out("rst_hold", 0, 1'b0, 1'b0);
            chk("rst_hold.pending", 32'(ftw_pending), 0);
            chk("rst_hold.active", ftw_active, 0);
        end

        en = 1'b1; ftw_in = '0; ftw_load = 1'b0; ftw_sync_mode = 1'b0;
        poff_in = '0; phase_clr = 1'b0;
        rst = 1'b1;
        chk("rel.valid_pre", 32'(phase_valid), 0);
        step();
        chk_out("rel", 0, 1'b1, 1'b0);

        // immediate load and full ramp
        ftw_in = 32'h0040_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        chk("imm.active", ftw_active, 32'h0040_0000);
        chk_out("imm0", 0, 1'b1, 1'b0);
        wraps = 0;
        for (int i = 1; i < 1024; i++) begin
            step();
            chk("ramp.phase", 32'(phase), 32'(i));
            if (wrap) wraps++;
        end
        chk("ramp.nowrap", 32'(wraps), 0);
        step();
        chk_out("ramp_wrap", 0, 1'b1, 1'b1);
        step();
        chk_out("ramp_after", 1, 1'b1, 1'b0);

        // deferred load
        ftw_in = 32'h4000_0000; ftw_load = 1'b1; phase_clr = 1'b1;
        step();
        ftw_load = 1'b0; phase_clr = 1'b0;
        chk_out("def_clr", 0, 1'b1, 1'b0);
        step();
        chk_out("def256", 256, 1'b1, 1'b0);
        ftw_in = 32'h8000_0000; ftw_load = 1'b1; ftw_sync_mode = 1'b1;
        step();
        ftw_load = 1'b0; ftw_sync_mode = 1'b0;
        chk_out("def512", 512, 1'b1, 1'b0);
        chk("def512.pending", 32'(ftw_pending), 1);
        step();
        chk_out("def768", 768, 1'b1, 1'b0);
        chk("def768.pending", 32'(ftw_pending), 1);
        chk("def768.active", ftw_active, 32'h4000_0000);
        step();
        chk_out("def_commit", 0, 1'b1, 1'b1);
        chk("def_commit.pending", 32'(ftw_pending), 0);
        chk("def_commit.active", ftw_active, 32'h8000_0000);
        step();
        chk_out("def_a", 512, 1'b1, 1'b0);
        step();
        chk_out("def_b", 0, 1'b1, 1'b1);
        step();
        chk_out("def_c", 512, 1'b1, 1'b0);

        // phase offset
        ftw_in = '0; ftw_load = 1'b1; phase_clr = 1'b1; poff_in = 32'h8000_0000;
        step();
        ftw_load = 1'b0; phase_clr = 1'b0;
        chk_out("off512", 512, 1'b1, 1'b0);
        poff_in = 32'h4000_0000;
        step();
        chk_out("off256", 256, 1'b1, 1'b0);
        poff_in = 32'hFFFF_FFFF;
        step();
        chk_out("off_max", 1023, 1'b1, 1'b0);
        ftw_in = 32'h0040_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        chk_out("off_max2", 1023, 1'b1, 1'b0);
        step();
        chk_out("off_roll", 0, 1'b1, 1'b0);
        poff_in = '0;
        step();
        chk_out("off_zero", 2, 1'b1, 1'b0);

        // enable hold
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("hold", 2, 1'b0, 1'b0);
        end
        en = 1'b1;
        step();
        chk_out("resume", 3, 1'b1, 1'b0);

        // clear mid-run
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        chk_out("clr", 0, 1'b1, 1'b0);
        step();
        chk_out("clr_after", 1, 1'b1, 1'b0);

        // clear suppresses wrap on a would-be carry
        ftw_in = 32'h8000_0000; ftw_load = 1'b1; phase_clr = 1'b1;
        step();
        ftw_load = 1'b0; phase_clr = 1'b0;
        chk_out("cw0", 0, 1'b1, 1'b0);
        step();
        chk_out("cw512", 512, 1'b1, 1'b0);
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        chk_out("cw_clr", 0, 1'b1, 1'b0);

        // commit coinciding with another deferred load
        ftw_in = 32'h4000_0000; ftw_load = 1'b1; ftw_sync_mode = 1'b1;
        step();
        chk_out("cl512", 512, 1'b1, 1'b0);
        chk("cl512.pending", 32'(ftw_pending), 1);
        ftw_in = 32'h2000_0000;
        step();
        ftw_load = 1'b0; ftw_sync_mode = 1'b0;
        chk_out("cl_commit", 0, 1'b1, 1'b1);
        chk("cl_commit.active", ftw_active, 32'h4000_0000);
        chk("cl_commit.pending", 32'(ftw_pending), 1);
        step();
        chk_out("cl256", 256, 1'b1, 1'b0);
        step();
        chk_out("cl512b", 512, 1'b1, 1'b0);
        step();
        chk_out("cl768", 768, 1'b1, 1'b0);
        step();
        chk_out("cl_commit2", 0, 1'b1, 1'b1);
        chk("cl_commit2.active", ftw_active, 32'h2000_0000);
        chk("cl_commit2.pending", 32'(ftw_pending), 0);
        step();
        chk_out("cl128", 128, 1'b1, 1'b0);

        // asynchronous reset while pending
        ftw_in = 32'h1000_0000; ftw_load = 1'b1; ftw_sync_mode = 1'b1;
        step();
        ftw_load = 1'b0; ftw_sync_mode = 1'b0;
        chk_out("ar_pre", 256, 1'b1, 1'b0);
        chk("ar_pre.pending", 32'(ftw_pending), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("ar_async", 0, 1'b0, 1'b0);
        chk("ar_async.pending", 32'(ftw_pending), 0);
        chk("ar_async.active", ftw_active, 0);
        step();
        rst = 1'b1;
        step();
        chk_out("ar_rel", 0, 1'b1, 1'b0);
        chk("ar_rel.active", ftw_active, 0);
        chk("ar_rel.pending", 32'(ftw_pending), 0);
        step();
        chk_out("ar_rel2", 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
